fir_ctrl: RTL and testbench
===========================

FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 Parameter TAP_COUNT, default 8: number of coefficient registers.
REQ-002 Parameter DATA_WIDTH, default 32: sample, tap and result width.
REQ-003 Parameter DECIMATION_FACTOR, default 1: samples fed to the FIR per result.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 enable  in  1  level; 1 = run, 0 = return to IDLE at the next frame boundary.
REQ-007 in_empty, in_dout  in  1, DATA_WIDTH  input FIFO, first-word-fall-through.
REQ-008 in_rd_en  out  1  pops the input FIFO.
REQ-009 fir_rd_en  in  1  FIR ready to accept a sample.
REQ-010 fir_data, fir_data_valid  out  DATA_WIDTH, 1  sample to FIR, qualified by valid.
REQ-011 fir_done, fir_result  in  1, DATA_WIDTH  FIR result strobe (1-cycle pulse) and value.
REQ-012 out_full  in  1; out_wr_en, out_din  out  1, DATA_WIDTH  output FIFO write port.
REQ-013 cfg_wr_en, cfg_addr, cfg_data  in  1, 8, DATA_WIDTH  tap write port.
REQ-014 taps  out  TAP_COUNT x DATA_WIDTH  coefficient bank driven to the FIR.
REQ-015 cfg_err  out  1  1-cycle pulse on a rejected cfg write.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 result_count  out  32  results written to the output FIFO since reset, wraps.

Function
REQ-018 States IDLE, FEED, WAIT_RESULT and WRITE SHALL be implemented in one registered FSM.
REQ-019 IDLE -> FEED when enable=1; all handshake outputs 0 in IDLE.
REQ-020 FEED: transfer when in_empty=0 and fir_rd_en=1; same cycle in_rd_en=1, fir_data_valid=1, fir_data=in_dout, zero latency.
REQ-021 FEED: no transfer: in_rd_en=0, fir_data_valid=0; feed counter holds.
REQ-022 The feed counter (8 bits) SHALL increment per transfer; on transfer DECIMATION_FACTOR-1, clear and go to WAIT_RESULT.
REQ-023 WAIT_RESULT: on fir_done=1, register fir_result into result_q and go to WRITE; otherwise wait indefinitely.
REQ-024 fir_done outside WAIT_RESULT SHALL be ignored.
REQ-025 WRITE: if out_full=0, out_wr_en=1, out_din=result_q, result_count+1, then FEED if enable=1 else IDLE.
REQ-026 WRITE with out_full=1: out_wr_en=0, hold state and result_q (back-pressure, no drop).
REQ-027 enable deassert mid-frame SHALL NOT abort; the frame completes through WRITE.
REQ-028 cfg write accepted only in IDLE with cfg_addr<TAP_COUNT: taps[cfg_addr]<=cfg_data next edge.
REQ-029 cfg write in a non-IDLE state or with cfg_addr>=TAP_COUNT: no tap change, cfg_err=1 next cycle.
REQ-030 A cfg write in the same cycle as IDLE->FEED SHALL be accepted (decision uses the registered state).
REQ-031 taps SHALL be stable from leaving IDLE to returning to IDLE.
REQ-032 result_count SHALL wrap 0xFFFFFFFF -> 0.

Reset
REQ-033 Reset SHALL force IDLE, feed counter 0, result_q 0, taps all 0, result_count 0.
REQ-034 All outputs SHALL be 0 during and immediately after reset.
REQ-035 Reset mid-frame SHALL discard the partial frame without an out_wr_en pulse.

Structure
REQ-036 Package fir_pkg SHALL hold DATA_WIDTH and TAP_COUNT defaults and the FSM state enum.
REQ-037 Sub-module fir_tap_bank SHALL hold the coefficient registers, address check and cfg_err generation.
REQ-038 All registers SHALL sit in a single clocked process with asynchronous reset; next-state logic SHALL be combinational.

Verification
REQ-039 Load taps 1..8 in IDLE, read back taps -> taps[i]=i+1, cfg_err never asserted.
REQ-040 DECIMATION_FACTOR=2, push 4 samples, FIR model returns 0x10 then 0x20 -> two out_wr_en with out_din 0x10, 0x20; result_count=2.
REQ-041 In FEED, toggle in_empty and fir_rd_en randomly -> in_rd_en asserted only when both permit; no sample lost or duplicated.
REQ-042 out_full=1 for 20 cycles during WRITE -> no write, result held; out_full=0 -> exactly one write of the held value.
REQ-043 cfg write to addr 3 while busy, and to addr 9 in IDLE -> taps unchanged, cfg_err pulses twice.
REQ-044 Assert reset in WAIT_RESULT, then fir_done -> no out_wr_en, state IDLE, result_count=0.

Source files
------------

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared defaults and FSM state encoding for the FIR sample controller
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 32;
  localparam int FIR_TAP_COUNT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_FEED        = 2'd1,
    ST_WAIT_RESULT = 2'd2,
    ST_WRITE       = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_tap_bank.sv
// rtl/fir_tap_bank.sv - coefficient registers with address check and rejected-write strobe
module fir_tap_bank
  import fir_pkg::*;
#(
  parameter int TAP_COUNT  = FIR_TAP_COUNT,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                i_idle,
  input  logic                                i_cfg_wr_en,
  input  logic [7:0]                          i_cfg_addr,
  input  logic [DATA_WIDTH-1:0]               i_cfg_data,
  output logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] o_taps,
  output logic                                o_cfg_err
);

  localparam logic [8:0] ADDR_LIMIT = 9'(TAP_COUNT);

  logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] r_taps;
  logic                                 r_cfg_err;
  logic                                 w_accept;

  // i_idle is the registered FSM state, so taps freeze for the whole busy period
  assign w_accept = i_cfg_wr_en && i_idle && ({1'b0, i_cfg_addr} < ADDR_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_taps    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= i_cfg_wr_en && !w_accept;
      for (int i = 0; i < TAP_COUNT; i++) begin
        if (w_accept && (i_cfg_addr == 8'(i))) begin
          r_taps[i] <= i_cfg_data;
        end
      end
    end
  end

  assign o_taps    = r_taps;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/fir_ctrl.sv
// rtl/fir_ctrl.sv - moves samples from an input FIFO into a FIR engine and its results to an output FIFO
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int TAP_COUNT         = FIR_TAP_COUNT,
  parameter int DATA_WIDTH        = FIR_DATA_WIDTH,
  parameter int DECIMATION_FACTOR = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                in_empty,
  input  logic [DATA_WIDTH-1:0]               in_dout,
  output logic                                in_rd_en,
  input  logic                                fir_rd_en,
  output logic [DATA_WIDTH-1:0]               fir_data,
  output logic                                fir_data_valid,
  input  logic                                fir_done,
  input  logic [DATA_WIDTH-1:0]               fir_result,
  input  logic                                out_full,
  output logic                                out_wr_en,
  output logic [DATA_WIDTH-1:0]               out_din,
  input  logic                                cfg_wr_en,
  input  logic [7:0]                          cfg_addr,
  input  logic [DATA_WIDTH-1:0]               cfg_data,
  output logic [TAP_COUNT-1:0][DATA_WIDTH-1:0] taps,
  output logic                                cfg_err,
  output logic                                busy,
  output logic [31:0]                         result_count
);

  localparam logic [7:0] LAST_FEED = 8'(DECIMATION_FACTOR - 1);

  fir_state_e            r_state;
  fir_state_e            w_next_state;
  logic [7:0]            r_feed_cnt;
  logic [DATA_WIDTH-1:0] r_result_q;
  logic [31:0]           r_result_count;
  logic                  w_xfer;
  logic                  w_last_feed;
  logic                  w_write;

  assign w_xfer      = (r_state == ST_FEED) && !in_empty && fir_rd_en;
  assign w_last_feed = (r_feed_cnt == LAST_FEED);
  assign w_write     = (r_state == ST_WRITE) && !out_full;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_feed_cnt     <= '0;
      r_result_q     <= '0;
      r_result_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_xfer) begin
        r_feed_cnt <= w_last_feed ? 8'd0 : r_feed_cnt + 8'd1;
      end
      if ((r_state == ST_WAIT_RESULT) && fir_done) begin
        r_result_q <= fir_result;
      end
      if (w_write) begin
        r_result_count <= r_result_count + 32'd1;
      end
    end
  end

  // enable is only sampled at frame boundaries so a started frame always completes
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:        if (enable) w_next_state = ST_FEED;
      ST_FEED:        if (w_xfer && w_last_feed) w_next_state = ST_WAIT_RESULT;
      ST_WAIT_RESULT: if (fir_done) w_next_state = ST_WRITE;
      ST_WRITE:       if (!out_full) w_next_state = enable ? ST_FEED : ST_IDLE;
      default:        w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_rd_en       = 1'b0;
    fir_data_valid = 1'b0;
    fir_data       = '0;
    out_wr_en      = 1'b0;
    out_din        = '0;
    busy           = (r_state != ST_IDLE);
    if (w_xfer) begin
      in_rd_en       = 1'b1;
      fir_data_valid = 1'b1;
      fir_data       = in_dout;
    end
    if (w_write) begin
      out_wr_en = 1'b1;
      out_din   = r_result_q;
    end
  end

  assign result_count = r_result_count;

  fir_tap_bank #(
    .TAP_COUNT  (TAP_COUNT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tap_bank (
    .clock       (clock),
    .reset       (reset),
    .i_idle      (r_state == ST_IDLE),
    .i_cfg_wr_en (cfg_wr_en),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_data  (cfg_data),
    .o_taps      (taps),
    .o_cfg_err   (cfg_err)
  );

endmodule

// File: tb/tb_fir_ctrl.sv
// tb/tb_fir_ctrl.sv - self-checking bench: FIFO/FIR models, result scoreboard, cfg vector table
module tb_fir_ctrl;

  localparam int TAPS = 8;
  localparam int DW   = 32;
  localparam int DEC  = 2;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      enable = 1'b0;
  logic                      in_empty = 1'b1;
  logic [DW-1:0]             in_dout = '0;
  logic                      in_rd_en;
  logic                      fir_rd_en = 1'b0;
  logic [DW-1:0]             fir_data;
  logic                      fir_data_valid;
  logic                      fir_done = 1'b0;
  logic [DW-1:0]             fir_result = '0;
  logic                      out_full = 1'b0;
  logic                      out_wr_en;
  logic [DW-1:0]             out_din;
  logic                      cfg_wr_en = 1'b0;
  logic [7:0]                cfg_addr = '0;
  logic [DW-1:0]             cfg_data = '0;
  logic [TAPS-1:0][DW-1:0]   taps;
  logic                      cfg_err;
  logic                      busy;
  logic [31:0]               result_count;

  fir_ctrl #(
    .TAP_COUNT         (TAPS),
    .DATA_WIDTH        (DW),
    .DECIMATION_FACTOR (DEC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .in_empty       (in_empty),
    .in_dout        (in_dout),
    .in_rd_en       (in_rd_en),
    .fir_rd_en      (fir_rd_en),
    .fir_data       (fir_data),
    .fir_data_valid (fir_data_valid),
    .fir_done       (fir_done),
    .fir_result     (fir_result),
    .out_full       (out_full),
    .out_wr_en      (out_wr_en),
    .out_din        (out_din),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .taps           (taps),
    .cfg_err        (cfg_err),
    .busy           (busy),
    .result_count   (result_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]    addr;
    logic [DW-1:0] data;
    logic          exp_err;
  } cfg_vec_t;

  cfg_vec_t                cfg_tbl[11];
  int                      n_cmp = 0;
  int                      n_err = 0;
  logic [DW-1:0]           in_fifo[$];
  logic [DW-1:0]           samp_q[$];
  logic [DW-1:0]           exp_q[$];
  logic [DW-1:0]           wr_log[$];
  int                      wr_count = 0;
  int                      err_count = 0;
  bit                      rand_mode = 1'b0;
  bit                      hold_full = 1'b0;
  bit                      pend_pop = 1'b0;
  bit                      pend_frame = 1'b0;
  bit                      force_done = 1'b0;
  bit                      gate_in = 1'b0;
  logic [DW-1:0]           force_res = '0;
  logic [DW-1:0]           acc = '0;
  logic [DW-1:0]           frame_res = '0;
  int                      nfeed = 0;
  int                      done_cnt = 0;
  int                      fir_lat = 2;
  int                      base;
  logic [TAPS-1:0][DW-1:0] exp_taps = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event not expected here", name);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic push_samp(input logic [DW-1:0] v);
    in_fifo.push_back(v);
    samp_q.push_back(v);
  endtask

  // Environment: input FIFO (FWFT), FIR engine, output FIFO full flag; updates just after each edge
  always @(posedge clock) begin
    #1;
    if (pend_pop && in_fifo.size() > 0) void'(in_fifo.pop_front());
    pend_pop = 1'b0;
    if (rand_mode) begin
      gate_in   = 1'($urandom_range(0, 1));
      fir_rd_en = 1'($urandom_range(0, 1));
    end else begin
      gate_in   = 1'b0;
      fir_rd_en = 1'b1;
    end
    in_empty   = (in_fifo.size() == 0) || gate_in;
    in_dout    = (in_fifo.size() > 0) ? in_fifo[0] : '0;
    fir_done   = 1'b0;
    fir_result = '0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        fir_done   = 1'b1;
        fir_result = frame_res;
        exp_q.push_back(frame_res);
      end
    end
    if (pend_frame) begin
      if (rand_mode) fir_lat = $urandom_range(1, 4);
      done_cnt   = fir_lat;
      pend_frame = 1'b0;
    end
    if (force_done) begin
      fir_done   = 1'b1;
      fir_result = force_res;
    end
    out_full = hold_full;
  end

  // Monitor: sample mid-cycle, check transfers and writes against the scoreboards
  always @(negedge clock) begin
    if (in_rd_en || fir_data_valid) begin
      chk("xfer_handshake", 32'({in_rd_en, fir_data_valid, in_empty, fir_rd_en}), 32'hD);
      if (samp_q.size() == 0) fail_now("sample_extra");
      else chk("sample_order", fir_data, samp_q.pop_front());
      acc = acc + fir_data;
      nfeed++;
      if (nfeed == DEC) begin
        frame_res  = acc;
        acc        = '0;
        nfeed      = 0;
        pend_frame = 1'b1;
      end
    end
    if (out_wr_en) begin
      wr_count++;
      wr_log.push_back(out_din);
      chk("wr_not_full", 32'(out_full), 32'd0);
      if (exp_q.size() == 0) fail_now("out_unexpected");
      else chk("out_din", out_din, exp_q.pop_front());
    end
    if (cfg_err) err_count++;
    pend_pop = in_rd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) cfg_tbl[i] = '{8'(i), DW'(i + 1), 1'b0};
    cfg_tbl[8]  = '{8'd8,   32'h0000_00AA, 1'b1};
    cfg_tbl[9]  = '{8'd9,   32'h0000_00BB, 1'b1};
    cfg_tbl[10] = '{8'd255, 32'h0000_00CC, 1'b1};

    tick(2);
    chk("rst_ctrl_outs", 32'({in_rd_en, fir_data_valid, out_wr_en, cfg_err, busy}), 32'd0);
    chk("rst_fir_data", fir_data, 32'd0);
    chk("rst_out_din", out_din, 32'd0);
    chk("rst_count", result_count, 32'd0);
    chk("rst_taps", 32'(taps == '0), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("post_rst_outs", 32'({in_rd_en, fir_data_valid, out_wr_en, cfg_err, busy}), 32'd0);

    // Tap writes in IDLE, including out-of-range addresses
    for (int i = 0; i < 11; i++) begin
      cfg_wr_en = 1'b1;
      cfg_addr  = cfg_tbl[i].addr;
      cfg_data  = cfg_tbl[i].data;
      tick(1);
      cfg_wr_en = 1'b0;
      chk($sformatf("cfg_err_%0d", i), 32'(cfg_err), 32'(cfg_tbl[i].exp_err));
      if (!cfg_tbl[i].exp_err) exp_taps[cfg_tbl[i].addr[2:0]] = cfg_tbl[i].data;
    end
    tick(1);
    for (int i = 0; i < TAPS; i++) chk($sformatf("tap_readback_%0d", i), taps[i], 32'(i + 1));
    chk("cfg_err_count_idle", 32'(err_count), 32'd3);

    // Two decimated frames: sums 7+9=0x10 and 0x11+0xF=0x20
    push_samp(32'h7); push_samp(32'h9); push_samp(32'h11); push_samp(32'hF);
    enable = 1'b1;
    for (int k = 0; k < 200 && wr_count < 1; k++) tick(1);
    enable = 1'b0;
    for (int k = 0; k < 200 && (wr_count < 2 || busy); k++) tick(1);
    chk("dec_wr_count", 32'(wr_count), 32'd2);
    chk("dec_out0", (wr_log.size() > 0) ? wr_log[0] : 32'hX, 32'h10);
    chk("dec_out1", (wr_log.size() > 1) ? wr_log[1] : 32'hX, 32'h20);
    chk("dec_result_count", result_count, 32'd2);
    chk("dec_taps_stable", 32'(taps == exp_taps), 32'd1);

    // Random FIFO-empty / FIR-ready toggling over ten frames
    rand_mode = 1'b1;
    for (int i = 0; i < 20; i++) push_samp($urandom);
    base   = wr_count;
    enable = 1'b1;
    for (int k = 0; k < 2000 && wr_count < base + 9; k++) tick(1);
    enable = 1'b0;
    for (int k = 0; k < 2000 && (wr_count < base + 10 || busy); k++) tick(1);
    rand_mode = 1'b0;
    chk("rand_wr_count", 32'(wr_count), 32'd12);
    chk("rand_samples_left", 32'(samp_q.size()), 32'd0);
    chk("rand_result_count", result_count, 32'd12);

    // Back-pressure in WRITE, plus a cfg write attempted while busy
    hold_full = 1'b1;
    push_samp(32'h100); push_samp(32'h23);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() < 1; k++) tick(1);
    tick(2);
    cfg_wr_en = 1'b1;
    cfg_addr  = 8'd3;
    cfg_data  = 32'hDEAD;
    tick(1);
    cfg_wr_en = 1'b0;
    chk("busy_cfg_err", 32'(cfg_err), 32'd1);
    base = wr_count;
    tick(20);
    chk("full_no_write", 32'(wr_count), 32'(base));
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_pending", 32'(exp_q.size()), 32'd1);
    hold_full = 1'b0;
    for (int k = 0; k < 20 && busy; k++) tick(1);
    chk("full_one_write", 32'(wr_count), 32'(base + 1));
    chk("full_value", wr_log[wr_log.size() - 1], 32'h123);
    chk("full_result_count", result_count, 32'd13);
    chk("busy_cfg_taps", 32'(taps == exp_taps), 32'd1);
    chk("cfg_err_count_all", 32'(err_count), 32'd4);

    // cfg write in the same cycle the FSM leaves IDLE
    enable    = 1'b1;
    cfg_wr_en = 1'b1;
    cfg_addr  = 8'd0;
    cfg_data  = 32'h55;
    tick(1);
    cfg_wr_en = 1'b0;
    enable    = 1'b0;
    chk("start_cfg_busy", 32'(busy), 32'd1);
    chk("start_cfg_tap0", taps[0], 32'h55);
    chk("start_cfg_no_err", 32'(cfg_err), 32'd0);
    push_samp(32'h1); push_samp(32'h2);
    for (int k = 0; k < 50 && busy; k++) tick(1);
    chk("start_cfg_count", result_count, 32'd14);

    // fir_done while IDLE is ignored
    base       = wr_count;
    force_res  = 32'h77;
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(3);
    chk("idle_done_ignored", 32'(wr_count), 32'(base));
    chk("idle_done_busy", 32'(busy), 32'd0);

    // Reset while waiting for a FIR result, then a late fir_done
    fir_lat = 30;
    push_samp(32'h5); push_samp(32'h6);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    for (int k = 0; k < 50 && done_cnt == 0; k++) tick(1);
    tick(2);
    chk("wait_busy", 32'(busy), 32'd1);
    base  = wr_count;
    reset = 1'b1;
    #1;
    chk("midrst_outs", 32'({in_rd_en, fir_data_valid, out_wr_en, busy}), 32'd0);
    chk("midrst_count", result_count, 32'd0);
    done_cnt = 0;
    exp_q.delete();
    acc   = '0;
    nfeed = 0;
    tick(2);
    reset      = 1'b0;
    fir_lat    = 2;
    force_res  = 32'h99;
    force_done = 1'b1;
    tick(1);
    force_done = 1'b0;
    tick(5);
    chk("midrst_no_write", 32'(wr_count), 32'(base));
    chk("midrst_idle", 32'(busy), 32'd0);
    chk("midrst_count_after", result_count, 32'd0);
    chk("midrst_taps", 32'(taps == '0), 32'd1);
    chk("final_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
